// File: rtl/median_filter.sv
// -----------------------------------------------------------------------------
// median_filter
// Streaming 3x3 median engine. A window of nine pixels is loaded serially into
// a nine-register ring (med), then sorted in place by one compare-exchange
// cell (mce) under control of the FSM below. The median leaves on DO together
// with a one-cycle DSO pulse.
//
// Ports (median_filter):
//   clk   in   1      system clock, rising edge
//   nRST  in   1      synchronous active-low reset
//   DI    in   WIDTH  pixel in, taken while DSI=1 and the block is accepting
//   DSI   in   1      data strobe in, high for nine consecutive pixels
//   DO    out  WIDTH  median out, valid only while DSO=1
//   DSO   out  1      one-cycle strobe marking DO valid
//
// Ring model used by the schedule (head = r_win[SIZE-1], tail = r_win[0]):
//   every non-load cycle removes the head and the element behind it, puts one
//   of them back as the new head and appends the other at the tail.
//     BYP=1 : plain rotation (old head to tail).
//     BYP=0 : larger value stays as head, smaller goes to the tail.
//   Pass p compares 8-p times (head collects the largest unsorted value) and
//   then rotates p+1 times, which parks that maximum behind the previously
//   parked ones and brings the unsorted part back to the front. After four
//   passes the four largest values are parked; four more compares leave the
//   largest of the remaining five -- the median -- at the head, i.e. on DO.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// mce: compare-exchange cell (unsigned).
//   i_a, i_b  in   WIDTH  operands
//   o_hi      out  WIDTH  max(i_a, i_b)
//   o_lo      out  WIDTH  min(i_a, i_b)
// -----------------------------------------------------------------------------
module mce #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    logic w_a_ge_b;

    assign w_a_ge_b = (i_a >= i_b);
    assign o_hi     = w_a_ge_b ? i_a : i_b;
    assign o_lo     = w_a_ge_b ? i_b : i_a;
endmodule

// -----------------------------------------------------------------------------
// med: nine-register compare/shift datapath. No reset: contents are
// meaningless until a full window has been loaded and sorted.
//   clk  in   1      clock
//   DI   in   WIDTH  pixel shifted in at the tail while DSI=1
//   DSI  in   1      load strobe (priority over BYP)
//   BYP  in   1      1 = rotate, 0 = compare-exchange head with next element
//   DO   out  WIDTH  current head of the ring
// -----------------------------------------------------------------------------
module med #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 9
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] DI,
    input  logic             DSI,
    input  logic             BYP,
    output logic [WIDTH-1:0] DO
);
    logic [WIDTH-1:0] r_win [SIZE];
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;

    mce #(.WIDTH(WIDTH)) u_mce (
        .i_a  (r_win[SIZE-1]),
        .i_b  (r_win[SIZE-2]),
        .o_hi (w_hi),
        .o_lo (w_lo)
    );

    always_ff @(posedge clk) begin
        // Body of the ring always advances by one position.
        for (int i = 1; i < SIZE-1; i++) begin
            r_win[i] <= r_win[i-1];
        end
        if (DSI) begin
            r_win[0]      <= DI;
            r_win[SIZE-1] <= r_win[SIZE-2];
        end else if (BYP) begin
            r_win[0]      <= r_win[SIZE-1];
            r_win[SIZE-1] <= r_win[SIZE-2];
        end else begin
            r_win[0]      <= w_lo;
            r_win[SIZE-1] <= w_hi;
        end
    end

    assign DO = r_win[SIZE-1];
endmodule

// -----------------------------------------------------------------------------
// median_filter: top level, control FSM plus datapath.
// -----------------------------------------------------------------------------
module median_filter #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 9      // only 9 is supported
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic [WIDTH-1:0] DI,
    input  logic             DSI,
    output logic [WIDTH-1:0] DO,
    output logic             DSO
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_PASS  = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Index of the last pixel / last cycle of a pass.
    localparam logic [3:0] LAST = 4'(SIZE - 1);

    state_t     r_state;
    logic [3:0] r_load_cnt;
    logic [3:0] r_c;
    logic [1:0] r_p;
    logic [1:0] r_fin_cnt;

    state_t     w_state_next;
    logic [3:0] w_load_next;
    logic [3:0] w_c_next;
    logic [1:0] w_p_next;
    logic [1:0] w_fin_next;

    logic       w_dsi;
    logic       w_byp;
    logic [3:0] w_cmp_len;

    // Number of compare cycles in the current pass: 8, 7, 6, 5.
    assign w_cmp_len = LAST - {2'b00, r_p};

    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_state    <= S_IDLE;
            r_load_cnt <= 4'd0;
            r_c        <= 4'd0;
            r_p        <= 2'd0;
            r_fin_cnt  <= 2'd0;
        end else begin
            r_state    <= w_state_next;
            r_load_cnt <= w_load_next;
            r_c        <= w_c_next;
            r_p        <= w_p_next;
            r_fin_cnt  <= w_fin_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_next  = r_load_cnt;
        w_c_next     = r_c;
        w_p_next     = r_p;
        w_fin_next   = r_fin_cnt;
        w_dsi        = 1'b0;
        w_byp        = 1'b1;

        unique case (r_state)
            S_IDLE: begin
                w_dsi = DSI;
                if (DSI) begin
                    w_state_next = S_LOAD;
                    w_load_next  = 4'd1;
                end
            end

            S_LOAD: begin
                w_dsi = DSI;
                if (!DSI) begin
                    // Short window: drop it, no result.
                    w_state_next = S_IDLE;
                    w_load_next  = 4'd0;
                end else if (r_load_cnt == LAST) begin
                    w_state_next = S_PASS;
                    w_load_next  = 4'd0;
                    w_c_next     = 4'd0;
                    w_p_next     = 2'd0;
                end else begin
                    w_load_next = r_load_cnt + 4'd1;
                end
            end

            S_PASS: begin
                w_byp = (r_c < w_cmp_len) ? 1'b0 : 1'b1;
                if (r_c == LAST) begin
                    w_c_next = 4'd0;
                    if (r_p == 2'd3) begin
                        w_state_next = S_FINAL;
                        w_p_next     = 2'd0;
                        w_fin_next   = 2'd0;
                    end else begin
                        w_p_next = r_p + 2'd1;
                    end
                end else begin
                    w_c_next = r_c + 4'd1;
                end
            end

            S_FINAL: begin
                w_byp = 1'b0;
                if (r_fin_cnt == 2'd3) begin
                    w_state_next = S_DONE;
                    w_fin_next   = 2'd0;
                end else begin
                    w_fin_next = r_fin_cnt + 2'd1;
                end
            end

            S_DONE: begin
                // The result is already on DO; a pixel arriving now opens
                // the next window without a bubble.
                w_dsi = DSI;
                if (DSI) begin
                    w_state_next = S_LOAD;
                    w_load_next  = 4'd1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_load_next  = 4'd0;
                w_c_next     = 4'd0;
                w_p_next     = 2'd0;
                w_fin_next   = 2'd0;
            end
        endcase
    end

    // Decoded from the state register only: no path from DSI.
    assign DSO = (r_state == S_DONE);

    med #(.WIDTH(WIDTH), .SIZE(SIZE)) u_med (
        .clk (clk),
        .DI  (DI),
        .DSI (w_dsi),
        .BYP (w_byp),
        .DO  (DO)
    );
endmodule
